// File: rtl/noc_pkg.sv
// Shared packet format and FSM state types for the node<->router byte-serial link.
package noc_pkg;

   typedef struct packed {
      logic [3:0]  src;
      logic [3:0]  dest;
      logic [23:0] data;
   } pkt_t;

   localparam int         BYTES_PER_PKT = 4;
   localparam logic [1:0] LAST_BYTE     = 2'(BYTES_PER_PKT - 1);

   typedef enum logic [1:0] {RX_IDLE, RX_RECV, RX_DROP} rx_state_e;
   typedef enum logic [1:0] {TX_IDLE, TX_SEND, TX_GAP}  tx_state_e;

   // Byte idx of a packet on the wire; byte 0 is the MSB byte.
   function automatic logic [7:0] pkt_byte(input pkt_t pkt, input logic [1:0] idx);
      logic [31:0] w;
      logic [7:0]  b;
      w = pkt;
      b = w[31:24];
      case (idx)
         2'd1:    b = w[23:16];
         2'd2:    b = w[15:8];
         2'd3:    b = w[7:0];
         default: b = w[31:24];
      endcase
      return b;
   endfunction

endpackage

// File: rtl/port_fifo.sv
// Show-ahead packet FIFO: data_out is the head entry whenever empty is low.
module port_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_b,
   input  logic [WIDTH-1:0]         data_in,
   input  logic                     we,
   input  logic                     re,
   output logic [WIDTH-1:0]         data_out,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int            AW       = $clog2(DEPTH);
   localparam int            CW       = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("port_fifo DEPTH must be a power of 2 and at least 2");
   end

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             do_push, do_pop;

   assign empty    = (count_q == '0);
   assign full     = (count_q == FULL_CNT);
   assign count    = count_q;
   assign data_out = mem_q[rd_ptr_q];

   // A full FIFO still accepts a push when the head leaves on the same edge.
   assign do_pop  = re & ~empty;
   assign do_push = we & (~full | do_pop);

   always_comb begin
      wr_ptr_d = wr_ptr_q + AW'(do_push);
      rd_ptr_d = rd_ptr_q + AW'(do_pop);
      count_d  = count_q + CW'(do_push) - CW'(do_pop);
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= data_in;
      end
   end

endmodule

// File: rtl/router_node_port.sv
// Router-side end of the node<->router byte-serial link: reassembles inbound
// 4-byte packets for the core and serialises core packets out to the node.
module router_node_port
   import noc_pkg::*;
#(
   parameter int NODEID   = 0,
   parameter int RX_DEPTH = 4,
   parameter int TX_DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst_b,
   input  logic       put_from_node,
   input  logic [7:0] payload_from_node,
   output logic       free_to_node,
   output logic       put_to_node,
   output logic [7:0] payload_to_node,
   input  logic       free_from_node,
   output pkt_t       rx_pkt,
   output logic       rx_valid,
   input  logic       rx_ready,
   output logic       rx_err,
   input  pkt_t       tx_pkt,
   input  logic       tx_valid,
   output logic       tx_ready
);

   localparam int RX_CW = $clog2(RX_DEPTH) + 1;
   localparam int RX_LW = RX_CW + 1;
   localparam int TX_CW = $clog2(TX_DEPTH) + 1;

   // Packets from a foreign src are still forwarded; the ID only has to fit the src field.
   if ((NODEID < 0) || (NODEID > 15)) begin : g_bad_nodeid
      $error("router_node_port NODEID must fit the 4-bit src field");
   end

   rx_state_e         rx_state_q, rx_state_d;
   logic [1:0]        rx_cnt_q, rx_cnt_d;
   logic [31:0]       rx_shift_q, rx_shift_d;
   logic              rx_err_q, rx_err_d;
   logic              free_q, free_d;
   logic [31:0]       rx_word, rx_head;
   logic              rx_push, rx_pop, rx_full, rx_empty;
   logic [RX_CW-1:0]  rx_count;
   logic [RX_LW-1:0]  rx_load;

   tx_state_e         tx_state_q, tx_state_d;
   logic [1:0]        tx_cnt_q, tx_cnt_d;
   logic [31:0]       tx_head;
   logic              tx_push, tx_pop, tx_full, tx_empty;
   logic [TX_CW-1:0]  tx_count;

   assign rx_word = {rx_shift_q[23:0], payload_from_node};
   assign rx_pop  = rx_ready & ~rx_empty;

   port_fifo #(.WIDTH(32), .DEPTH(RX_DEPTH)) u_rx_fifo (
      .clk      (clk),
      .rst_b    (rst_b),
      .data_in  (rx_word),
      .we       (rx_push),
      .re       (rx_ready),
      .data_out (rx_head),
      .full     (rx_full),
      .empty    (rx_empty),
      .count    (rx_count)
   );

   always_comb begin
      rx_state_d = rx_state_q;
      rx_cnt_d   = rx_cnt_q;
      rx_shift_d = rx_shift_q;
      rx_err_d   = 1'b0;
      rx_push    = 1'b0;
      case (rx_state_q)
         RX_IDLE: begin
            if (put_from_node) begin
               if (free_q) begin
                  rx_shift_d = rx_word;
                  rx_cnt_d   = 2'd1;
                  rx_state_d = RX_RECV;
               end else begin
                  rx_state_d = RX_DROP;
               end
            end
         end
         RX_RECV: begin
            if (put_from_node) begin
               rx_shift_d = rx_word;
               if (rx_cnt_q == LAST_BYTE) begin
                  rx_push    = 1'b1;
                  rx_err_d   = rx_full & ~rx_pop;
                  rx_cnt_d   = 2'd0;
                  rx_state_d = RX_IDLE;
               end else begin
                  rx_cnt_d = rx_cnt_q + 2'd1;
               end
            end else begin
               rx_err_d   = 1'b1;
               rx_cnt_d   = 2'd0;
               rx_state_d = RX_IDLE;
            end
         end
         RX_DROP: begin
            if (!put_from_node) begin
               rx_err_d   = 1'b1;
               rx_state_d = RX_IDLE;
            end
         end
         default: rx_state_d = RX_IDLE;
      endcase
      // Occupancy after this edge's pop, plus any packet still arriving on the wire.
      rx_load = {1'b0, rx_count} - RX_LW'(rx_pop)
              + RX_LW'((rx_state_q == RX_RECV) || put_from_node);
      free_d  = (rx_load < RX_LW'(RX_DEPTH));
   end

   assign rx_pkt       = pkt_t'(rx_head);
   assign rx_valid     = ~rx_empty;
   assign rx_err       = rx_err_q;
   assign free_to_node = free_q;

   assign tx_pop   = (tx_state_q == TX_SEND) && (tx_cnt_q == LAST_BYTE);
   assign tx_ready = (tx_count < TX_CW'(TX_DEPTH)) | (tx_full & tx_pop);
   assign tx_push  = tx_valid & tx_ready;

   port_fifo #(.WIDTH(32), .DEPTH(TX_DEPTH)) u_tx_fifo (
      .clk      (clk),
      .rst_b    (rst_b),
      .data_in  (tx_pkt),
      .we       (tx_push),
      .re       (tx_pop),
      .data_out (tx_head),
      .full     (tx_full),
      .empty    (tx_empty),
      .count    (tx_count)
   );

   // TX_GAP forces a quiet cycle so the node's free is re-sampled after it reacts to the packet.
   always_comb begin
      tx_state_d = tx_state_q;
      tx_cnt_d   = tx_cnt_q;
      case (tx_state_q)
         TX_IDLE: begin
            if (!tx_empty && free_from_node) begin
               tx_cnt_d   = 2'd0;
               tx_state_d = TX_SEND;
            end
         end
         TX_SEND: begin
            if (tx_cnt_q == LAST_BYTE) begin
               tx_cnt_d   = 2'd0;
               tx_state_d = TX_GAP;
            end else begin
               tx_cnt_d = tx_cnt_q + 2'd1;
            end
         end
         TX_GAP:  tx_state_d = TX_IDLE;
         default: tx_state_d = TX_IDLE;
      endcase
   end

   assign put_to_node     = (tx_state_q == TX_SEND);
   assign payload_to_node = put_to_node ? pkt_byte(pkt_t'(tx_head), tx_cnt_q) : 8'h00;

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         rx_state_q <= RX_IDLE;
         rx_cnt_q   <= 2'd0;
         rx_shift_q <= 32'h0;
         rx_err_q   <= 1'b0;
         free_q     <= 1'b1;
         tx_state_q <= TX_IDLE;
         tx_cnt_q   <= 2'd0;
      end else begin
         rx_state_q <= rx_state_d;
         rx_cnt_q   <= rx_cnt_d;
         rx_shift_q <= rx_shift_d;
         rx_err_q   <= rx_err_d;
         free_q     <= free_d;
         tx_state_q <= tx_state_d;
         tx_cnt_q   <= tx_cnt_d;
      end
   end

endmodule

// File: tb/tb_router_node_port.sv
// Directed bench for router_node_port: inbound reassembly, backpressure, error drop,
// outbound serialisation with node free gating, and reset mid-packet.
module tb_router_node_port;
   import noc_pkg::*;

   logic        clk = 1'b0;
   logic        rst_b = 1'b0;
   logic        put_from_node = 1'b0;
   logic [7:0]  payload_from_node = 8'h00;
   logic        free_to_node;
   logic        put_to_node;
   logic [7:0]  payload_to_node;
   logic        free_from_node;
   pkt_t        rx_pkt;
   logic        rx_valid;
   logic        rx_ready = 1'b0;
   logic        rx_err;
   logic [31:0] tx_pkt = 32'h0;
   logic        tx_valid = 1'b0;
   logic        tx_ready;
   logic        node_hold = 1'b0;

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;

   logic [31:0] p [4];
   logic [31:0] q [2];

   router_node_port #(.NODEID(0), .RX_DEPTH(4), .TX_DEPTH(4)) dut (
      .clk               (clk),
      .rst_b             (rst_b),
      .put_from_node     (put_from_node),
      .payload_from_node (payload_from_node),
      .free_to_node      (free_to_node),
      .put_to_node       (put_to_node),
      .payload_to_node   (payload_to_node),
      .free_from_node    (free_from_node),
      .rx_pkt            (rx_pkt),
      .rx_valid          (rx_valid),
      .rx_ready          (rx_ready),
      .rx_err            (rx_err),
      .tx_pkt            (tx_pkt),
      .tx_valid          (tx_valid),
      .tx_ready          (tx_ready)
   );

   always #5 clk = ~clk;

   // Node model: free stays low for the cycle after each byte it receives.
   always @(posedge clk) begin
      free_from_node <= node_hold ? 1'b0 : ~put_to_node;
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic send_bytes(input logic [31:0] pk);
      for (int i = 0; i < 4; i++) begin
         put_from_node     = 1'b1;
         payload_from_node = pk[31-8*i -: 8];
         tick();
      end
   endtask

   initial begin
      p[0] = 32'h1A000001; p[1] = 32'h2B000002; p[2] = 32'h3C000003; p[3] = 32'h4D000004;
      q[0] = 32'h11223344; q[1] = 32'h55667788;

      // Reset values
      repeat (3) tick();
      check("rst_free", free_to_node, 1);
      check("rst_put", put_to_node, 0);
      check("rst_payload", payload_to_node, 8'h00);
      check("rst_rxv", rx_valid, 0);
      check("rst_rxerr", rx_err, 0);
      check("rst_txrdy", tx_ready, 1);
      rst_b = 1'b1;
      tick();

      // 1: single inbound packet
      for (int i = 0; i < 4; i++) begin
         put_from_node     = 1'b1;
         payload_from_node = 8'h12 + 8'(i * 8'h22);
         tick();
         check("t1_free", free_to_node, 1);
         check("t1_rxv_timing", rx_valid, (i == 3) ? 1 : 0);
      end
      put_from_node = 1'b0;
      check("t1_pkt", rx_pkt, 32'h12345678);
      check("t1_err", rx_err, 0);
      rx_ready = 1'b1;
      tick();
      rx_ready = 1'b0;
      check("t1_pop", rx_valid, 0);

      // 2: backpressure with RX buffer filling up
      for (int k = 0; k < 3; k++) send_bytes(p[k]);
      check("t2_free_before4", free_to_node, 1);
      put_from_node     = 1'b1;
      payload_from_node = p[3][31:24];
      tick();
      check("t2_free_low", free_to_node, 0);
      payload_from_node = p[3][23:16]; tick();
      payload_from_node = p[3][15:8];  tick();
      payload_from_node = p[3][7:0];   tick();
      // node ignores free: run right after the 4th byte is discarded
      payload_from_node = 8'h99; tick();
      tick();
      put_from_node = 1'b0;
      tick();
      check("t2_drop_err", rx_err, 1);
      check("t2_full_free", free_to_node, 0);
      check("t2_head", rx_pkt, p[0]);
      rx_ready = 1'b1;
      tick();
      rx_ready = 1'b0;
      check("t2_free_after_pop", free_to_node, 1);
      check("t2_err_pulse", rx_err, 0);
      for (int k = 1; k < 4; k++) begin
         check("t2_order", rx_pkt, p[k]);
         rx_ready = 1'b1;
         tick();
         rx_ready = 1'b0;
      end
      check("t2_empty", rx_valid, 0);

      // 3: short packet then a good one
      put_from_node = 1'b1; payload_from_node = 8'hAA; tick();
      payload_from_node = 8'hBB; tick();
      put_from_node = 1'b0;
      tick();
      check("t3_err", rx_err, 1);
      check("t3_rxv", rx_valid, 0);
      tick();
      check("t3_err_once", rx_err, 0);
      send_bytes(32'h0F1E2D3C);
      put_from_node = 1'b0;
      check("t3_rxv_good", rx_valid, 1);
      check("t3_pkt", rx_pkt, 32'h0F1E2D3C);
      rx_ready = 1'b1;
      tick();
      rx_ready = 1'b0;

      // 4: single outbound packet
      check("t4_txrdy", tx_ready, 1);
      tx_pkt   = 32'hA1B2C3D4;
      tx_valid = 1'b1;
      tick();
      tx_valid = 1'b0;
      check("t4_put_early", put_to_node, 0);
      tick();
      for (int i = 0; i < 4; i++) begin
         check("t4_put", put_to_node, 1);
         check("t4_byte", payload_to_node, 8'hA1 + 8'(i * 8'h11));
         tick();
      end
      check("t4_put_end", put_to_node, 0);
      check("t4_payload_idle", payload_to_node, 8'h00);
      tick();
      tick();

      // 5: two packets gated by node free
      tx_pkt = q[0]; tx_valid = 1'b1; tick();
      tx_pkt = q[1]; tick();
      tx_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check("t5_put_a", put_to_node, 1);
         check("t5_byte_a", payload_to_node, q[0][31-8*i -: 8]);
         tick();
      end
      check("t5_gap_put", put_to_node, 0);
      check("t5_gap_free", free_from_node, 0);
      tick();
      check("t5_wait_put", put_to_node, 0);
      check("t5_wait_free", free_from_node, 1);
      tick();
      for (int i = 0; i < 4; i++) begin
         check("t5_put_b", put_to_node, 1);
         check("t5_byte_b", payload_to_node, q[1][31-8*i -: 8]);
         tick();
      end
      check("t5_done", put_to_node, 0);
      tick();
      tick();

      // 6: fill TX while node busy, then reset mid-packet
      node_hold = 1'b1;
      tick();
      for (int k = 0; k < 4; k++) begin
         check("t6_txrdy_fill", tx_ready, 1);
         tx_pkt   = p[k];
         tx_valid = 1'b1;
         tick();
      end
      tx_valid = 1'b0;
      check("t6_txrdy_full", tx_ready, 0);
      check("t6_held", put_to_node, 0);
      node_hold = 1'b0;
      tick();
      check("t6_wait_free", put_to_node, 0);
      tick();
      check("t6_b0", payload_to_node, p[0][31:24]);
      tick();
      check("t6_b1", payload_to_node, p[0][23:16]);
      tick();
      rst_b = 1'b0;
      #1;
      check("t6_rst_put", put_to_node, 0);
      check("t6_rst_payload", payload_to_node, 8'h00);
      check("t6_rst_txrdy", tx_ready, 1);
      check("t6_rst_free", free_to_node, 1);
      tick();
      rst_b = 1'b1;
      repeat (4) tick();
      check("t6_after_put", put_to_node, 0);
      check("t6_after_txrdy", tx_ready, 1);
      check("t6_after_free", free_to_node, 1);
      check("t6_after_rxv", rx_valid, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
